// File: rtl/bexkat1Def.sv
// Shared bexkat1 definitions: forwarding codes, SP forwarding codes, instruction types.
// Latency: n/a (constants only).
// Backpressure: n/a.
package bexkat1Def;

  // Operand forwarding select codes (hazard1/hazard2)
  localparam logic [2:0] FWD_RF     = 3'd0;
  localparam logic [2:0] FWD_MEM    = 3'd1;
  localparam logic [2:0] FWD_EXE    = 3'd2;
  localparam logic [2:0] FWD_MEM_SP = 3'd3;
  localparam logic [2:0] FWD_EXE_SP = 3'd4;

  // Stack pointer forwarding select codes (sp_hazard)
  localparam logic [1:0] SPF_RF  = 2'd0;
  localparam logic [1:0] SPF_EXE = 2'd1;
  localparam logic [1:0] SPF_MEM = 2'd2;

  // Instruction type field values, as decoded by the hazard unit
  localparam logic [3:0] T_INH  = 4'h0;
  localparam logic [3:0] T_PUSH = 4'h1;
  localparam logic [3:0] T_POP  = 4'h2;
  localparam logic [3:0] T_CMP  = 4'h3;
  localparam logic [3:0] T_MOV  = 4'h4;
  localparam logic [3:0] T_FP   = 4'h5;
  localparam logic [3:0] T_ALU  = 4'h6;
  localparam logic [3:0] T_INT  = 4'h7;
  localparam logic [3:0] T_LDI  = 4'h8;
  localparam logic [3:0] T_LOAD = 4'h9;
  localparam logic [3:0] T_STORE= 4'ha;
  localparam logic [3:0] T_BRANCH = 4'hb;
  localparam logic [3:0] T_JUMP = 4'hc;

endpackage

// File: rtl/fwd_mux.sv
// Operand forwarding mux: picks one 32-bit operand from RF or EXE/MEM results.
// Latency: combinational, zero cycles.
// Backpressure: none; illegal select codes fall back to the register file.
module fwd_mux
  import bexkat1Def::*;
(
  input  logic [2:0]  sel,
  input  logic [31:0] rf_data,
  input  logic [31:0] mem_result,
  input  logic [31:0] exe_result,
  input  logic [31:0] mem_sp_next,
  input  logic [31:0] exe_sp_next,
  output logic [31:0] dat
);

  // Select the operand source; codes 5..7 read the register file
  always_comb begin
    dat = rf_data;
    case (sel)
      FWD_MEM:    dat = mem_result;
      FWD_EXE:    dat = exe_result;
      FWD_MEM_SP: dat = mem_sp_next;
      FWD_EXE_SP: dat = exe_sp_next;
      default:    dat = rf_data;
    endcase
  end

endmodule

// File: rtl/id_operand_stage.sv
// ID/EXE pipeline register with operand/SP forwarding; optional stats via BEXKAT1_FWD_STATS_EN.
// Latency: one cycle from ID inputs to EXE outputs.
// Backpressure: hold freezes all state (flush deferred), stall/flush insert a bubble; if_hold = stall | hold.
module id_operand_stage
  import bexkat1Def::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [63:0] id_ir,
  input  logic [31:0] id_pc,
  input  logic [1:0]  id_reg_write,
  input  logic [1:0]  id_sp_write,
  input  logic [31:0] rf_data1,
  input  logic [31:0] rf_data2,
  input  logic [31:0] rf_sp,
  input  logic [31:0] exe_result,
  input  logic [31:0] mem_result,
  input  logic [31:0] exe_sp_next,
  input  logic [31:0] mem_sp_next,
  input  logic [2:0]  hazard1,
  input  logic [2:0]  hazard2,
  input  logic [1:0]  sp_hazard,
  input  logic        stall,
  input  logic        hold,
  input  logic        flush,
  output logic [63:0] exe_ir,
  output logic [31:0] exe_pc,
  output logic [31:0] exe_data1,
  output logic [31:0] exe_data2,
  output logic [31:0] exe_sp,
  output logic [1:0]  exe_reg_write,
  output logic [1:0]  exe_sp_write,
  output logic        if_hold
`ifdef BEXKAT1_FWD_STATS_EN
  ,
  output logic [31:0] fwd_count,
  output logic [31:0] bubble_count
`endif
);

  logic [31:0] data1_sel;
  logic [31:0] data2_sel;
  logic [31:0] sp_sel;
  logic        flush_pend;
  logic        do_bubble;
  logic        do_advance;

  fwd_mux u_fwd1 (
    .sel         (hazard1),
    .rf_data     (rf_data1),
    .mem_result  (mem_result),
    .exe_result  (exe_result),
    .mem_sp_next (mem_sp_next),
    .exe_sp_next (exe_sp_next),
    .dat         (data1_sel)
  );

  fwd_mux u_fwd2 (
    .sel         (hazard2),
    .rf_data     (rf_data2),
    .mem_result  (mem_result),
    .exe_result  (exe_result),
    .mem_sp_next (mem_sp_next),
    .exe_sp_next (exe_sp_next),
    .dat         (data2_sel)
  );

  // SP forwarding select; code 3 is illegal and reads the architectural SP
  always_comb begin
    sp_sel = rf_sp;
    case (sp_hazard)
      SPF_EXE: sp_sel = exe_sp_next;
      SPF_MEM: sp_sel = mem_sp_next;
      default: sp_sel = rf_sp;
    endcase
  end

  // IF/ID freezes on stall or hold only; a flush lets IF/ID refill
  assign if_hold    = stall | hold;
  assign do_bubble  = !hold && (flush || flush_pend || stall);
  assign do_advance = !hold && !(flush || flush_pend || stall);

  // Pipeline register: hold beats bubble beats advance; flush during hold is remembered
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      exe_ir        <= 64'h0;
      exe_pc        <= 32'h0;
      exe_data1     <= 32'h0;
      exe_data2     <= 32'h0;
      exe_sp        <= 32'h0;
      exe_reg_write <= 2'b00;
      exe_sp_write  <= 2'b00;
      flush_pend    <= 1'b0;
    end else if (hold) begin
      if (flush) flush_pend <= 1'b1;
    end else if (do_bubble) begin
      exe_ir        <= 64'h0;
      exe_pc        <= 32'h0;
      exe_data1     <= 32'h0;
      exe_data2     <= 32'h0;
      exe_sp        <= 32'h0;
      exe_reg_write <= 2'b00;
      exe_sp_write  <= 2'b00;
      flush_pend    <= 1'b0;
    end else begin
      exe_ir        <= id_ir;
      exe_pc        <= id_pc;
      exe_data1     <= data1_sel;
      exe_data2     <= data2_sel;
      exe_sp        <= sp_sel;
      exe_reg_write <= id_reg_write;
      exe_sp_write  <= id_sp_write;
    end
  end

`ifdef BEXKAT1_FWD_STATS_EN
  // Statistics: forwarded advances and inserted bubbles, both wrapping, frozen in hold
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fwd_count    <= 32'h0;
      bubble_count <= 32'h0;
    end else begin
      if (do_advance && (hazard1 != FWD_RF || hazard2 != FWD_RF || sp_hazard != SPF_RF))
        fwd_count <= fwd_count + 32'd1;
      if (do_bubble)
        bubble_count <= bubble_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_operand_stage.sv
// Bench for id_operand_stage: directed vectors plus a cycle model checked every cycle.
// Latency: model predicts EXE outputs one edge after inputs are presented.
// Backpressure: exercises stall, hold, deferred flush and reset-in-hold.
module tb_id_operand_stage;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [63:0] id_ir;
  logic [31:0] id_pc;
  logic [1:0]  id_reg_write, id_sp_write;
  logic [31:0] rf_data1, rf_data2, rf_sp;
  logic [31:0] exe_result, mem_result, exe_sp_next, mem_sp_next;
  logic [2:0]  hazard1, hazard2;
  logic [1:0]  sp_hazard;
  logic        stall, hold, flush;
  logic [63:0] exe_ir;
  logic [31:0] exe_pc, exe_data1, exe_data2, exe_sp;
  logic [1:0]  exe_reg_write, exe_sp_write;
  logic        if_hold;
`ifdef BEXKAT1_FWD_STATS_EN
  logic [31:0] fwd_count, bubble_count;
`endif

  int checks = 0;
  int fails  = 0;

  always #5 clk_i = ~clk_i;

  id_operand_stage dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .id_ir(id_ir), .id_pc(id_pc),
    .id_reg_write(id_reg_write), .id_sp_write(id_sp_write),
    .rf_data1(rf_data1), .rf_data2(rf_data2), .rf_sp(rf_sp),
    .exe_result(exe_result), .mem_result(mem_result),
    .exe_sp_next(exe_sp_next), .mem_sp_next(mem_sp_next),
    .hazard1(hazard1), .hazard2(hazard2), .sp_hazard(sp_hazard),
    .stall(stall), .hold(hold), .flush(flush),
    .exe_ir(exe_ir), .exe_pc(exe_pc),
    .exe_data1(exe_data1), .exe_data2(exe_data2), .exe_sp(exe_sp),
    .exe_reg_write(exe_reg_write), .exe_sp_write(exe_sp_write),
    .if_hold(if_hold)
`ifdef BEXKAT1_FWD_STATS_EN
    , .fwd_count(fwd_count), .bubble_count(bubble_count)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [63:0] m_ir;
  logic [31:0] m_pc, m_d1, m_d2, m_sp;
  logic [1:0]  m_rw, m_sw;
  bit          m_owed_bubble;   // flush seen while frozen, still to be paid
  int unsigned m_fwd, m_bub;
  bit          m_valid = 0;

  function automatic logic [31:0] pick_op(input logic [2:0] code, input logic [31:0] rf);
    logic [31:0] srcs [8];
    srcs = '{rf, mem_result, exe_result, mem_sp_next, exe_sp_next, rf, rf, rf};
    return srcs[code];
  endfunction

  function automatic logic [31:0] pick_sp(input logic [1:0] code);
    logic [31:0] srcs [4];
    srcs = '{rf_sp, exe_sp_next, mem_sp_next, rf_sp};
    return srcs[code];
  endfunction

  always @(posedge clk_i) begin
    if (rst_i) begin
      {m_ir, m_pc, m_d1, m_d2, m_sp, m_rw, m_sw} = '0;
      m_owed_bubble = 0; m_fwd = 0; m_bub = 0;
      m_valid = 1;
    end else if (hold) begin
      m_owed_bubble = m_owed_bubble | flush;
    end else if (flush || stall || m_owed_bubble) begin
      {m_ir, m_pc, m_d1, m_d2, m_sp, m_rw, m_sw} = '0;
      m_owed_bubble = 0;
      m_bub++;
    end else begin
      m_ir = id_ir; m_pc = id_pc; m_rw = id_reg_write; m_sw = id_sp_write;
      m_d1 = pick_op(hazard1, rf_data1);
      m_d2 = pick_op(hazard2, rf_data2);
      m_sp = pick_sp(sp_hazard);
      if (hazard1 != 0 || hazard2 != 0 || sp_hazard != 0) m_fwd++;
    end
  end

  // Compare process: every negedge once the model has seen a reset edge
  always @(negedge clk_i) begin
    if (m_valid) begin
      chk("m_exe_ir", exe_ir, m_ir);
      chk("m_exe_pc", {32'h0, exe_pc}, {32'h0, m_pc});
      chk("m_exe_data1", {32'h0, exe_data1}, {32'h0, m_d1});
      chk("m_exe_data2", {32'h0, exe_data2}, {32'h0, m_d2});
      chk("m_exe_sp", {32'h0, exe_sp}, {32'h0, m_sp});
      chk("m_exe_we", {60'h0, exe_reg_write, exe_sp_write}, {60'h0, m_rw, m_sw});
      chk("m_if_hold", {63'h0, if_hold}, {63'h0, (stall | hold)});
`ifdef BEXKAT1_FWD_STATS_EN
      chk("m_fwd_count", {32'h0, fwd_count}, {32'h0, m_fwd});
      chk("m_bubble_count", {32'h0, bubble_count}, {32'h0, m_bub});
`endif
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk_i);
    @(negedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    id_ir = 64'h0; id_pc = 32'h0; id_reg_write = 2'b00; id_sp_write = 2'b00;
    rf_data1 = 32'h0; rf_data2 = 32'h0; rf_sp = 32'h0;
    exe_result = 32'h0; mem_result = 32'h0; exe_sp_next = 32'h0; mem_sp_next = 32'h0;
    hazard1 = 3'd0; hazard2 = 3'd0; sp_hazard = 2'd0;
    stall = 0; hold = 0; flush = 0;
  endtask

  initial begin
    idle_inputs();
    rst_i = 1;
    tick(); tick();
    chk("rst_exe_ir", exe_ir, 64'h0);
    chk("rst_exe_data1", {32'h0, exe_data1}, 64'h0);
    chk("rst_exe_we", {60'h0, exe_reg_write, exe_sp_write}, 64'h0);
    rst_i = 0;

    // forward from EXE on port 1
    id_ir = 64'h1; id_pc = 32'h100; id_reg_write = 2'b01;
    hazard1 = 3'd2; exe_result = 32'hDEADBEEF; rf_data1 = 32'h11111111;
    tick();
    chk("fwd_exe_data1", {32'h0, exe_data1}, 64'hDEADBEEF);
    chk("fwd_exe_ir", exe_ir, 64'h1);
`ifdef BEXKAT1_FWD_STATS_EN
    chk("fwd_count_1", {32'h0, fwd_count}, 64'd1);
`endif

    // illegal code on port 2 falls back to the RF
    hazard1 = 3'd0; hazard2 = 3'd7; rf_data2 = 32'h1234; mem_result = 32'h5555;
    id_ir = 64'h2;
    tick();
    chk("illegal_data2", {32'h0, exe_data2}, 64'h1234);
    chk("illegal_data1_rf", {32'h0, exe_data1}, 64'h11111111);

    // load-use stall: one bubble
    hazard2 = 3'd0; stall = 1; id_ir = 64'h3; id_reg_write = 2'b11;
    tick();
    chk("stall_if_hold", {63'h0, if_hold}, 64'h1);
    chk("stall_exe_ir", exe_ir, 64'h0);
    chk("stall_exe_rw", {62'h0, exe_reg_write}, 64'h0);
`ifdef BEXKAT1_FWD_STATS_EN
    chk("bubble_count_1", {32'h0, bubble_count}, 64'd1);
`endif
    stall = 0; id_ir = 64'h4;
    tick();
    chk("post_stall_ir", exe_ir, 64'h4);

    // hold 3 cycles with flush in the 2nd, then deferred bubble, then advance
    hold = 1; id_ir = 64'h5;
    tick(); chk("hold1_ir", exe_ir, 64'h4);
    flush = 1;
    tick(); chk("hold2_ir", exe_ir, 64'h4);
    flush = 0;
    tick(); chk("hold3_ir", exe_ir, 64'h4);
    hold = 0;
    tick(); chk("pend_bubble_ir", exe_ir, 64'h0);
    id_ir = 64'h6;
    tick(); chk("after_pend_ir", exe_ir, 64'h6);

    // SP forwarded from MEM
    sp_hazard = 2'd2; mem_sp_next = 32'h0000FFF0; rf_sp = 32'h0; exe_sp_next = 32'h77;
    id_ir = 64'h7;
    tick(); chk("sp_mem", {32'h0, exe_sp}, 64'h0000FFF0);
    sp_hazard = 2'd3; rf_sp = 32'hABCD; id_ir = 64'h71;
    tick(); chk("sp_illegal", {32'h0, exe_sp}, 64'hABCD);
    sp_hazard = 2'd0;

    // flush + stall together: a single bubble
    flush = 1; stall = 1; id_ir = 64'h9;
    tick(); chk("flush_stall_ir", exe_ir, 64'h0);
    flush = 0; stall = 0; id_ir = 64'hA;
    tick(); chk("flush_stall_next", exe_ir, 64'hA);

    // reset during a hold with a pending flush discards it
    hold = 1; flush = 1; id_ir = 64'hB;
    tick(); chk("hold_flush_ir", exe_ir, 64'hA);
    rst_i = 1; flush = 0;
    tick(); chk("rst_hold_ir", exe_ir, 64'h0);
    chk("rst_hold_if_hold", {63'h0, if_hold}, 64'h1);
    rst_i = 0; hold = 0; id_ir = 64'h8; id_pc = 32'h800;
    tick(); chk("rst_no_bubble_ir", exe_ir, 64'h8);
    chk("rst_no_bubble_pc", {32'h0, exe_pc}, 64'h800);

    // pseudo-random traffic checked by the model
    for (int i = 0; i < 40; i++) begin
      id_ir = {$urandom, $urandom}; id_pc = $urandom;
      id_reg_write = 2'($urandom); id_sp_write = 2'($urandom);
      rf_data1 = $urandom; rf_data2 = $urandom; rf_sp = $urandom;
      exe_result = $urandom; mem_result = $urandom;
      exe_sp_next = $urandom; mem_sp_next = $urandom;
      hazard1 = 3'($urandom); hazard2 = 3'($urandom); sp_hazard = 2'($urandom);
      stall = ($urandom_range(0, 5) == 0);
      hold  = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 5) == 0);
      tick();
    end

    idle_inputs();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
